// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel-tick divider, h/v counters, registered sync/de/coords/strobes.
// Define VGA_TG_FRAMECNT_EN to build the 16-bit frame counter; otherwise frame_cnt is tied to 0.
module vga_timing_gen #(
    parameter int CLK_DIV  = 2,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = 16
) (
    input  logic          CLOCK_50,
    input  logic          RESET_N,
    input  logic          enable,
    output logic          pix_tick,
    output logic          hs,
    output logic          vs,
    output logic          de,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start,
    output logic [15:0]   frame_cnt
);
    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] D_LAST     = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_SYNC_END = CW'(H_SYNC);
    localparam logic [CW-1:0] V_SYNC_END = CW'(V_SYNC);
    localparam logic [CW-1:0] H_ACT_LO   = CW'(H_SYNC + H_BP);
    localparam logic [CW-1:0] H_ACT_HI   = CW'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [CW-1:0] V_ACT_LO   = CW'(V_SYNC + V_BP);
    localparam logic [CW-1:0] V_ACT_HI   = CW'(V_SYNC + V_BP + V_ACTIVE);

    logic [DW-1:0] d_q, d_d;
    logic          tick_q, tick_d;
    logic [CW-1:0] h_q, h_d, v_q, v_d;
    logic          hs_q, hs_d, vs_q, vs_d, de_q, de_d;
    logic [CW-1:0] x_q, x_d, y_q, y_d;
    logic          ls_q, ls_d, fs_q, fs_d;
    logic          adv, h_wrap, f_wrap, h_act, v_act;

    assign adv    = enable && tick_q;
    assign h_wrap = adv && (h_q == H_LAST);
    assign f_wrap = h_wrap && (v_q == V_LAST);

    // With enable low every register keeps its value; the pulse outputs are masked below.
    always_comb begin
        d_d    = d_q;
        tick_d = tick_q;
        h_d    = h_q;
        v_d    = v_q;
        ls_d   = ls_q;
        fs_d   = fs_q;
        if (enable) begin
            tick_d = (d_q == D_LAST);
            d_d    = (d_q == D_LAST) ? '0 : d_q + 1'b1;
            ls_d   = h_wrap;
            fs_d   = f_wrap;
            if (adv) begin
                h_d = h_wrap ? '0 : h_q + 1'b1;
                if (h_wrap) begin
                    v_d = f_wrap ? '0 : v_q + 1'b1;
                end
            end
        end
    end

    // Decode from the next counter values so outputs change on the same edge as (h,v).
    always_comb begin
        h_act = (h_d >= H_ACT_LO) && (h_d < H_ACT_HI);
        v_act = (v_d >= V_ACT_LO) && (v_d < V_ACT_HI);
        hs_d  = (h_d < H_SYNC_END) ? HS_POL : ~HS_POL;
        vs_d  = (v_d < V_SYNC_END) ? VS_POL : ~VS_POL;
        de_d  = h_act && v_act;
        x_d   = de_d ? h_d - H_ACT_LO : '0;
        y_d   = de_d ? v_d - V_ACT_LO : '0;
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            d_q    <= '0;
            tick_q <= 1'b0;
            h_q    <= H_LAST;
            v_q    <= V_LAST;
            hs_q   <= ~HS_POL;
            vs_q   <= ~VS_POL;
            de_q   <= 1'b0;
            x_q    <= '0;
            y_q    <= '0;
            ls_q   <= 1'b0;
            fs_q   <= 1'b0;
        end else begin
            d_q    <= d_d;
            tick_q <= tick_d;
            h_q    <= h_d;
            v_q    <= v_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            de_q   <= de_d;
            x_q    <= x_d;
            y_q    <= y_d;
            ls_q   <= ls_d;
            fs_q   <= fs_d;
        end
    end

    assign pix_tick    = tick_q && enable;
    assign line_start  = ls_q && enable;
    assign frame_start = fs_q && enable;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign de          = de_q;
    assign x           = x_q;
    assign y           = y_q;

`ifdef VGA_TG_FRAMECNT_EN
    logic [15:0] fcnt_q, fcnt_d;

    always_comb begin
        fcnt_d = f_wrap ? fcnt_q + 16'd1 : fcnt_q;
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            fcnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_d;
        end
    end

    assign frame_cnt = fcnt_q;
`else
    assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two configurations checked each clock against an arithmetic raster model,
// plus directed latency/period/stall/reset checks with literal expectations.
module tb_vga_timing_gen;
    localparam int AD = 1, AHS = 2, AHB = 1, AHA = 4, AHF = 1, AVS = 1, AVB = 1, AVA = 3, AVF = 1;
    localparam bit AHP = 1'b1, AVP = 1'b1;
    localparam int BD = 3, BHS = 3, BHB = 2, BHA = 5, BHF = 2, BVS = 2, BVB = 2, BVA = 4, BVF = 1;
    localparam bit BHP = 1'b0, BVP = 1'b0;

    localparam int TICK_A = 0, LS_A = 1, FS_A = 2, DE_A = 3, LAST_A = 4, X1_A = 5;
    localparam int TICK_B = 6, LS_B = 7, FS_B = 8, MID_B = 9;

    typedef struct packed {
        logic        tick, hs, vs, de, ls, fs;
        logic [15:0] x, y, fc;
    } vid_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en_a = 1'b1;
    logic en_b = 1'b1;
    logic tick_a, hs_a, vs_a, de_a, ls_a, fs_a;
    logic tick_b, hs_b, vs_b, de_b, ls_b, fs_b;
    logic [15:0] x_a, y_a, fc_a, x_b, y_b, fc_b;

    longint e_a, e_b;
    int     cyc = 0;
    int     checks = 0;
    int     errors = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .CLK_DIV(AD), .H_SYNC(AHS), .H_BP(AHB), .H_ACTIVE(AHA), .H_FP(AHF),
        .V_SYNC(AVS), .V_BP(AVB), .V_ACTIVE(AVA), .V_FP(AVF),
        .HS_POL(AHP), .VS_POL(AVP), .CW(16)
    ) dut_a (
        .CLOCK_50(clk), .RESET_N(rst_n), .enable(en_a), .pix_tick(tick_a),
        .hs(hs_a), .vs(vs_a), .de(de_a), .x(x_a), .y(y_a),
        .line_start(ls_a), .frame_start(fs_a), .frame_cnt(fc_a)
    );

    vga_timing_gen #(
        .CLK_DIV(BD), .H_SYNC(BHS), .H_BP(BHB), .H_ACTIVE(BHA), .H_FP(BHF),
        .V_SYNC(BVS), .V_BP(BVB), .V_ACTIVE(BVA), .V_FP(BVF),
        .HS_POL(BHP), .VS_POL(BVP), .CW(16)
    ) dut_b (
        .CLOCK_50(clk), .RESET_N(rst_n), .enable(en_b), .pix_tick(tick_b),
        .hs(hs_b), .vs(vs_b), .de(de_b), .x(x_b), .y(y_b),
        .line_start(ls_b), .frame_start(fs_b), .frame_cnt(fc_b)
    );

    // Enabled clock edges since the last reset: the model's only notion of time.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_a <= 0;
            e_b <= 0;
        end else begin
            if (en_a) e_a <= e_a + 1;
            if (en_b) e_b <= e_b + 1;
        end
    end

    function automatic longint adv_n(longint e, int d);
        return (e >= 1) ? (e - 1) / d : 0;
    endfunction

    // Pixel n (1-based) after reset sits at raster position n-1 modulo the frame; n=0 is the reset position.
    function automatic vid_t model(int d, int hsl, int hb, int ha, int hf, int vsl, int vb, int va, int vf,
                                   bit hp, bit vp, longint e, bit en);
        vid_t   r;
        int     ht, vt, h, v;
        longint n, p;
        bit     moved;
        ht    = hsl + hb + ha + hf;
        vt    = vsl + vb + va + vf;
        n     = adv_n(e, d);
        moved = (e >= 1) && (n != adv_n(e - 1, d));
        if (n == 0) begin
            h = ht - 1;
            v = vt - 1;
        end else begin
            p = (n - 1) % longint'(ht * vt);
            h = int'(p % ht);
            v = int'(p / ht);
        end
        r.tick = en && (e >= 1) && (e % d == 0);
        r.hs   = (h < hsl) ? hp : ~hp;
        r.vs   = (v < vsl) ? vp : ~vp;
        r.de   = (h >= hsl + hb) && (h < hsl + hb + ha) && (v >= vsl + vb) && (v < vsl + vb + va);
        r.x    = r.de ? 16'(h - hsl - hb) : 16'd0;
        r.y    = r.de ? 16'(v - vsl - vb) : 16'd0;
        r.ls   = en && moved && (h == 0);
        r.fs   = en && moved && (h == 0) && (v == 0);
`ifdef VGA_TG_FRAMECNT_EN
        r.fc   = (n == 0) ? 16'd0 : 16'((n - 1) / longint'(ht * vt) + 1);
`else
        r.fc   = 16'd0;
`endif
        return r;
    endfunction

    task automatic cmp_one(input string name, input vid_t got, input vid_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual tick/hs/vs/de/ls/fs=%b%b%b%b%b%b x=%0d y=%0d fc=%0d required %b%b%b%b%b%b x=%0d y=%0d fc=%0d",
                     name, cyc, got.tick, got.hs, got.vs, got.de, got.ls, got.fs, got.x, got.y, got.fc,
                     exp.tick, exp.hs, exp.vs, exp.de, exp.ls, exp.fs, exp.x, exp.y, exp.fc);
        end
    endtask

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s cyc=%0d actual %0d required %0d", name, cyc, act, req);
        end
    endtask

    // Every clock step compares both DUTs against the model at the falling edge.
    task automatic step();
        vid_t ga, gb;
        @(negedge clk);
        cyc++;
        ga = {tick_a, hs_a, vs_a, de_a, ls_a, fs_a, x_a, y_a, fc_a};
        gb = {tick_b, hs_b, vs_b, de_b, ls_b, fs_b, x_b, y_b, fc_b};
        cmp_one("model_a", ga, model(AD, AHS, AHB, AHA, AHF, AVS, AVB, AVA, AVF, AHP, AVP, e_a, en_a));
        cmp_one("model_b", gb, model(BD, BHS, BHB, BHA, BHF, BVS, BVB, BVA, BVF, BHP, BVP, e_b, en_b));
    endtask

    function automatic bit probe(int which);
        case (which)
            TICK_A:  return tick_a;
            LS_A:    return ls_a;
            FS_A:    return fs_a;
            DE_A:    return de_a;
            LAST_A:  return de_a && x_a == 16'd3 && y_a == 16'd2;
            X1_A:    return de_a && x_a == 16'd1;
            TICK_B:  return tick_b;
            LS_B:    return ls_b;
            FS_B:    return fs_b;
            MID_B:   return de_b && y_b == 16'd2;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int which, input int limit, output int t);
        bit hit;
        hit = 1'b0;
        t   = -1;
        for (int i = 0; i < limit && !hit; i++) begin
            step();
            if (probe(which)) begin
                hit = 1'b1;
                t   = cyc;
            end
        end
        if (!hit) begin
            checks++;
            errors++;
            $display("FAIL wait_event_%0d cyc=%0d actual timeout after %0d clocks required event", which, cyc, limit);
        end
    endtask

    initial begin
        int t0, t1, r, cnt;
        int fa_tick, fa_fs, fb_tick, fb_fs;
        logic [15:0] xh, c0;

        repeat (3) step();
        chk("rst_hs_a", hs_a, 0);
        chk("rst_vs_a", vs_a, 0);
        chk("rst_hs_b", hs_b, 1);
        chk("rst_vs_b", vs_b, 1);
        chk("rst_de_a", de_a, 0);
        chk("rst_x_b", x_b, 0);
        chk("rst_tick_b", tick_b, 0);

        // First tick and frame entry latency after release.
        rst_n   = 1'b1;
        r       = cyc;
        fa_tick = -1; fa_fs = -1; fb_tick = -1; fb_fs = -1;
        repeat (6) begin
            step();
            if (tick_a && fa_tick < 0) fa_tick = cyc - r;
            if (fs_a && fa_fs < 0) begin
                fa_fs = cyc - r;
                chk("first_fs_hs_a", hs_a, 1);
            end
            if (tick_b && fb_tick < 0) fb_tick = cyc - r;
            if (fs_b && fb_fs < 0) begin
                fb_fs = cyc - r;
                chk("first_fs_vs_b", vs_b, 0);
            end
        end
        chk("lat_tick_a", fa_tick, 1);
        chk("lat_fs_a", fa_fs, 2);
        chk("lat_tick_b", fb_tick, 3);
        chk("lat_fs_b", fb_fs, 4);

        // Free-run periods.
        wait_for(LS_A, 20, t0);
        wait_for(LS_A, 20, t1);
        chk("line_period_a", t1 - t0, 8);
        cnt = 0;
        repeat (8) begin
            step();
            if (hs_a) cnt++;
        end
        chk("hs_high_clocks_a", cnt, 2);
        wait_for(FS_A, 60, t0);
        wait_for(FS_A, 60, t1);
        chk("frame_period_a", t1 - t0, 48);
        wait_for(TICK_B, 10, t0);
        wait_for(TICK_B, 10, t1);
        chk("tick_period_b", t1 - t0, 3);
        wait_for(LS_B, 60, t0);
        cnt = 0;
        repeat (36) begin
            if (!hs_b) cnt++;
            step();
        end
        chk("hs_low_clocks_b", cnt, 9);
        wait_for(FS_B, 400, t0);
        wait_for(FS_B, 400, t1);
        chk("frame_period_b", t1 - t0, 324);

        // Active-area corners on A.
        wait_for(FS_A, 60, t0);
        wait_for(DE_A, 60, t1);
        chk("de_rise_x_a", x_a, 0);
        chk("de_rise_y_a", y_a, 0);
        wait_for(LAST_A, 60, t1);
        step();
        chk("after_last_de_a", de_a, 0);
        chk("after_last_x_a", x_a, 0);

        // Enable stall of 37 clocks mid-line on A.
        wait_for(FS_A, 60, t0);
        wait_for(X1_A, 60, t1);
        en_a = 1'b0;
        xh   = x_a;
        cnt  = 0;
        repeat (37) begin
            step();
            if (ls_a || fs_a || tick_a) cnt++;
        end
        chk("stall_pulses_a", cnt, 0);
        chk("stall_x_hold_a", x_a, xh);
        chk("stall_de_hold_a", de_a, 1);
        en_a = 1'b1;
        step();
        chk("resume_x_a", x_a, xh + 16'd1);
        wait_for(FS_A, 200, t1);
        chk("stall_frame_period_a", t1 - t0, 85);

        // Reset in mid-frame.
        wait_for(MID_B, 400, t0);
        rst_n = 1'b0;
        #1;
        chk("midrst_hs_b", hs_b, 1);
        chk("midrst_vs_b", vs_b, 1);
        chk("midrst_de_b", de_b, 0);
        chk("midrst_x_b", x_b, 0);
        chk("midrst_y_b", y_b, 0);
        chk("midrst_fc_b", fc_b, 0);
        repeat (2) step();
        rst_n = 1'b1;
        r     = cyc;
        wait_for(FS_B, 10, t1);
        chk("midrst_fs_lat_b", t1 - r, 4);
        chk("midrst_fs_hs_b", hs_b, 0);
        chk("midrst_fs_vs_b", vs_b, 0);

`ifdef VGA_TG_FRAMECNT_EN
        wait_for(FS_A, 60, t0);
        c0 = fc_a;
        wait_for(FS_A, 60, t1);
        chk("frame_cnt_step_a", fc_a, c0 + 16'd1);
`else
        wait_for(FS_A, 60, t0);
        c0 = 16'd0;
        chk("frame_cnt_tied_a", fc_a, c0);
        chk("frame_cnt_tied_b", fc_b, c0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
